alu_muldiv: RTL and testbench

Execute-stage ALU that consumes the 4-bit `ALU_Ctrl` codes produced by the ALU control decoder. It performs the single-cycle logic, arithmetic and compare operations, and it owns the HI/LO register pair. Signed MULT and DIV run on a 33-cycle iterative engine, with a busy/stall handshake back to the pipeline control. MFHI and MFLO read HI and LO.

---
 rtl/alu_muldiv.sv | 185 ++++++++++++++++++
 tb/tb_alu_muldiv.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv
// Execute-stage ALU driven by the 4-bit ALU_Ctrl code from the ALU control
// decoder. It covers the single-cycle logic, arithmetic and compare operations
// and owns the HI/LO register pair. Signed MULT and DIV run on an iterative
// engine: one shift-add or restoring-division step per cycle, then a sign-fix
// cycle. The engine tells pipeline control when it is busy and when to stall.
//
// Ports
//   clk      : single clock
//   rst      : synchronous, active-high reset
//   start    : the instruction in EX is valid this cycle
//   ALU_Ctrl : operation code
//   A, B     : operands (A from rs, B from rt or the immediate)
//   Result   : combinational result of single-cycle ops, MFHI and MFLO
//   Zero     : Result == 0
//   busy     : the MULT/DIV engine is running (RUN or FIX state)
//   stall    : upstream must hold the EX instruction
//   done     : one-cycle pulse in the cycle after HI/LO are written

module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALU_Ctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    state_t           state;
    logic [5:0]       count;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             sign_a;
    logic             sign_b;
    logic             op_mult;
    logic             b_zero;

    // Shared working pair: partial product {acc_hi, acc_lo} during MULT,
    // remainder (acc_hi) and dividend/quotient shifter (acc_lo) during DIV.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               is_muldiv;
    logic               accept;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;
    logic               slt;

    assign abs_a     = A[WIDTH-1] ? -A : A;
    assign abs_b     = B[WIDTH-1] ? -B : B;
    assign is_muldiv = (ALU_Ctrl[3:1] == 3'b100);
    assign accept    = start && is_muldiv && (state == IDLE);

    assign busy  = (state != IDLE);
    // Codes 1000..1011 are MULT, DIV, MFHI, MFLO: all need the engine idle.
    assign stall = busy && start && (ALU_Ctrl[3:2] == 2'b10);

    // Shift-add step: add the multiplicand when the current multiplier bit is
    // set, then shift the whole {carry, acc_hi, acc_lo} right by one.
    assign mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_a : '0)};
    assign mul_next = {mul_sum, acc_lo[WIDTH-1:1]};

    // Restoring step: bring in the next dividend bit and keep the difference
    // only if it did not go negative. A zero divisor always "succeeds", which
    // leaves the remainder equal to |A| and the quotient all ones.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

    // Sign correction applied in FIX. The remainder takes the dividend's sign;
    // divide-by-zero forces LO to all ones regardless of operand signs.
    assign prod       = {acc_hi, acc_lo};
    assign prod_fixed = (sign_a ^ sign_b) ? -prod : prod;
    assign quot_fixed = b_zero ? '1 : ((sign_a ^ sign_b) ? -acc_lo : acc_lo);
    assign rem_fixed  = sign_a ? -acc_hi : acc_hi;

    assign slt = ($signed(A) < $signed(B));

    always_comb begin
        Result = '0;
        unique case (ALU_Ctrl)
            4'b0000, 4'b0101, 4'b1100, 4'b1101: Result = A + B;
            4'b0001, 4'b0110:                   Result = A - B;
            4'b0010:                            Result = A & B;
            4'b0011:                            Result = A | B;
            4'b0100:                            Result = ~(A | B);
            4'b0111:                            Result = {{(WIDTH-1){1'b0}}, slt};
            4'b1010:                            Result = hi;
            4'b1011:                            Result = lo;
            default:                            Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            op_mult <= 1'b0;
            b_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mag_a   <= abs_a;
                        mag_b   <= abs_b;
                        sign_a  <= A[WIDTH-1];
                        sign_b  <= B[WIDTH-1];
                        op_mult <= ALU_Ctrl[0];
                        b_zero  <= (B == '0);
                        count   <= '0;
                        acc_hi  <= '0;
                        acc_lo  <= ALU_Ctrl[0] ? abs_b : abs_a;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (op_mult) begin
                        acc_hi <= mul_next[2*WIDTH-1:WIDTH];
                        acc_lo <= mul_next[WIDTH-1:0];
                    end else begin
                        acc_hi <= div_rem;
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    end
                    count <= count + 6'd1;
                    if (count == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (op_mult) begin
                        hi <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo <= prod_fixed[WIDTH-1:0];
                    end else begin
                        hi <= rem_fixed;
                        lo <= quot_fixed;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv
// Directed bench for alu_muldiv: reset state, single-cycle ALU ops, signed
// MULT/DIV results and latency, divide-by-zero, stall behaviour while the
// engine runs, reset abort mid-DIV, and back-to-back MULT/DIV issue.

module tb_alu_muldiv;

    localparam logic [3:0] OP_SW   = 4'b0000;
    localparam logic [3:0] OP_BEQ  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_DIV  = 4'b1000;
    localparam logic [3:0] OP_MULT = 4'b1001;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;
    localparam logic [3:0] OP_ADDI = 4'b1100;
    localparam logic [3:0] OP_LW   = 4'b1101;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        stall;
    logic        done;

    int n_checks;
    int n_fail;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ALU_Ctrl (ctrl),
        .A        (a),
        .B        (b),
        .Result   (result),
        .Zero     (zero),
        .busy     (busy),
        .stall    (stall),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a MULT/DIV, then wait (bounded) for busy to drop. Returns in the
    // cycle after busy falls, with the number of busy cycles seen.
    task automatic issue_op(input logic [3:0] op, input logic [31:0] op_a,
                            input logic [31:0] op_b, output int busy_cycles,
                            output logic saw_done);
        start = 1'b1;
        ctrl  = op;
        a     = op_a;
        b     = op_b;
        tick();
        start = 1'b0;
        ctrl  = OP_ADD;
        a     = '0;
        b     = '0;
        busy_cycles = 0;
        while (busy && busy_cycles < 60) begin
            busy_cycles++;
            tick();
        end
        saw_done = done;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        ctrl  = OP_ADD;
        a     = '0;
        b     = '0;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_done: got %b expected 0", done);
        end
        ctrl = OP_MFHI;
        #1;
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_hi: got %h expected 00000000", result);
        end
        ctrl = OP_MFLO;
        #1;
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_lo: got %h expected 00000000", result);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp;
    } alu_vec_t;

    task automatic test_alu();
        alu_vec_t vecs[14];
        vecs[0]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[1]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vecs[2]  = '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        vecs[3]  = '{OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE};
        vecs[4]  = '{OP_BEQ,  32'h12345678, 32'h12345678, 32'h00000000};
        vecs[5]  = '{OP_AND,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000};
        vecs[6]  = '{OP_OR,   32'hF0F00000, 32'h0000000F, 32'hF0F0000F};
        vecs[7]  = '{OP_NOR,  32'hF0F00000, 32'h0000000F, 32'h0F0FFFF0};
        vecs[8]  = '{OP_SW,   32'h00001000, 32'h00000024, 32'h00001024};
        vecs[9]  = '{OP_ADDI, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
        vecs[10] = '{OP_LW,   32'h00000010, 32'hFFFFFFFC, 32'h0000000C};
        vecs[11] = '{4'b1110, 32'h00000010, 32'h00000020, 32'h00000000};
        vecs[12] = '{4'b1111, 32'h00000010, 32'h00000020, 32'h00000000};
        vecs[13] = '{OP_MULT, 32'h00000003, 32'h00000004, 32'h00000000};
        start = 1'b0;
        foreach (vecs[i]) begin
            ctrl = vecs[i].op;
            a    = vecs[i].va;
            b    = vecs[i].vb;
            #1;
            n_checks++;
            if (result !== vecs[i].exp) begin
                n_fail++;
                $display("[TB] FAIL alu_vec%0d op=%b: got %h expected %h",
                         i, vecs[i].op, result, vecs[i].exp);
            end
            n_checks++;
            if (zero !== (vecs[i].exp == 32'h0)) begin
                n_fail++;
                $display("[TB] FAIL alu_zero%0d: got %b expected %b",
                         i, zero, (vecs[i].exp == 32'h0));
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL alu_no_start_busy: got %b expected 0", busy);
        end
    endtask

    // Runs one MULT/DIV and checks latency, done, HI and LO in the done cycle.
    task automatic check_muldiv(input string name, input logic [3:0] op,
                                input logic [31:0] op_a, input logic [31:0] op_b,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   cycles;
        logic got_done;
        issue_op(op, op_a, op_b, cycles, got_done);
        n_checks++;
        if (cycles !== 33) begin
            n_fail++;
            $display("[TB] FAIL %s_latency: got %0d busy cycles expected 33", name, cycles);
        end
        n_checks++;
        if (got_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s_done: got %b expected 1", name, got_done);
        end
        ctrl = OP_MFHI;
        #1;
        n_checks++;
        if (result !== exp_hi) begin
            n_fail++;
            $display("[TB] FAIL %s_hi: got %h expected %h", name, result, exp_hi);
        end
        ctrl = OP_MFLO;
        #1;
        n_checks++;
        if (result !== exp_lo) begin
            n_fail++;
            $display("[TB] FAIL %s_lo: got %h expected %h", name, result, exp_lo);
        end
        ctrl = OP_ADD;
    endtask

    task automatic test_mult();
        check_muldiv("mult_neg3x7", OP_MULT, 32'hFFFFFFFD, 32'h00000007,
                     32'hFFFFFFFF, 32'hFFFFFFEB);
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mult_done_pulse: got %b expected 0", done);
        end
        check_muldiv("mult_min", OP_MULT, 32'h80000000, 32'h80000000,
                     32'h40000000, 32'h00000000);
        tick();
    endtask

    task automatic test_div();
        check_muldiv("div_neg7by2", OP_DIV, 32'hFFFFFFF9, 32'h00000002,
                     32'hFFFFFFFF, 32'hFFFFFFFD);
        tick();
    endtask

    task automatic test_div_zero();
        check_muldiv("div_by_zero", OP_DIV, 32'h00000005, 32'h00000000,
                     32'h00000005, 32'hFFFFFFFF);
        tick();
    endtask

    // LO holds 0xFFFFFFFF from the divide-by-zero test on entry.
    task automatic test_stall();
        int stall_cycles;
        start = 1'b1;
        ctrl  = OP_MULT;
        a     = 32'd100;
        b     = 32'd3;
        tick();
        ctrl = OP_AND;
        a    = 32'h000000FF;
        b    = 32'h0000000F;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stall_and_proceeds: got %b expected 0", stall);
        end
        n_checks++;
        if (result !== 32'h0000000F) begin
            n_fail++;
            $display("[TB] FAIL stall_and_result: got %h expected 0000000F", result);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL stall_busy: got %b expected 1", busy);
        end
        tick();
        ctrl = OP_MULT;
        a    = 32'd2;
        b    = 32'd2;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL stall_mult_in_busy: got %b expected 1", stall);
        end
        tick();
        ctrl = OP_MFLO;
        a    = '0;
        b    = '0;
        #1;
        n_checks++;
        if (result !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("[TB] FAIL stall_old_lo: got %h expected FFFFFFFF", result);
        end
        stall_cycles = 0;
        while (stall && stall_cycles < 60) begin
            stall_cycles++;
            tick();
        end
        n_checks++;
        if (stall_cycles !== 31) begin
            n_fail++;
            $display("[TB] FAIL stall_mflo_cycles: got %0d expected 31", stall_cycles);
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL stall_done: got %b expected 1", done);
        end
        n_checks++;
        if (result !== 32'd300) begin
            n_fail++;
            $display("[TB] FAIL stall_new_lo: got %h expected 0000012C", result);
        end
        start = 1'b0;
        ctrl  = OP_ADD;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stall_no_restart: got busy=%b done=%b expected 0 0",
                     busy, done);
        end
    endtask

    task automatic test_reset_abort();
        int done_seen;
        start = 1'b1;
        ctrl  = OP_DIV;
        a     = 32'd100;
        b     = 32'd7;
        tick();
        start = 1'b0;
        ctrl  = OP_ADD;
        a     = '0;
        b     = '0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_busy: got %b expected 0", busy);
        end
        ctrl = OP_MFHI;
        #1;
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL abort_hi: got %h expected 00000000", result);
        end
        ctrl = OP_MFLO;
        #1;
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL abort_lo: got %h expected 00000000", result);
        end
        ctrl = OP_ADD;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            tick();
        end
        n_checks++;
        if (done_seen !== 0) begin
            n_fail++;
            $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", done_seen);
        end
        check_muldiv("after_abort_6x7", OP_MULT, 32'd6, 32'd7, 32'h0, 32'd42);
        tick();
    endtask

    // The DIV is issued in the done cycle of the MULT.
    task automatic test_back_to_back();
        check_muldiv("b2b_mult", OP_MULT, 32'hFFFFFFFE, 32'd3,
                     32'hFFFFFFFF, 32'hFFFFFFFA);
        check_muldiv("b2b_div", OP_DIV, 32'd100, 32'hFFFFFFF9,
                     32'h00000002, 32'hFFFFFFF2);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        ctrl     = OP_ADD;
        a        = '0;
        b        = '0;
        test_reset();
        test_alu();
        test_mult();
        test_div();
        test_div_zero();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
